lane_merge_fifo: RTL

LANE_MERGE_FIFO -- requirements
Module: lane_merge_fifo

---
 rtl/lane_merge_pkg.sv | 11 +
 rtl/lane_merge_fifo_lane_fifo.sv | 62 ++++++
 rtl/lane_merge_fifo.sv | 108 ++++++++++
 3 files changed

// File: rtl/lane_merge_pkg.sv
// Shared constants and helpers for the two-lane merge FIFO.
package lane_merge_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/lane_merge_fifo_lane_fifo.sv
// Single-lane FIFO: storage, wrapping pointers, occupancy and registered status flags.
module lane_fifo
  import lane_merge_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = 6
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              push_ok, pop_ok;

  // A push into a full lane is dropped even if the lane is popped this cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop_ok)      cnt_nxt = cnt + CW'(1);
    else if (!push_ok && pop_ok) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      cnt         <= cnt_nxt;
      empty       <= (cnt_nxt == '0);
      full        <= (cnt_nxt == CW'(DEPTH));
      almost_full <= (cnt_nxt >= CW'(AF_THRESH));
      overflow    <= overflow | (push & full);
    end
  end

  always_ff @(posedge gclk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/lane_merge_fifo.sv
// Two-lane merge FIFO with round-robin pop arbitration and a registered output.
// Optional LANE_MERGE_DROP_COUNT_EN adds saturating per-lane drop counters.
module lane_merge_fifo
  import lane_merge_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = 6
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in0,
  input  logic              valid_in1,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_out,
  output logic              empty,
  output logic              full0,
  output logic              full1,
  output logic              almost_full0,
  output logic              almost_full1,
  output logic              overflow0,
  output logic              overflow1
`ifdef LANE_MERGE_DROP_COUNT_EN
  ,
  output logic [7:0]        drop_cnt0,
  output logic [7:0]        drop_cnt1
`endif
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0][DATA_W-1:0] wr_data, rd_data;
  logic [NUM_LANES-1:0] push, lane_pop, l_empty, l_full, l_af, l_ovf;
  logic                 sel, pop_ok, last_served;

  assign wr_data = {data_in1, data_in0};
  assign push    = {valid_in1, valid_in0};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_fifo (
      .gclk        (clk_2f),
      .grst_n      (reset),
      .push        (push[i]),
      .pop         (lane_pop[i]),
      .wr_data     (wr_data[i]),
      .rd_data     (rd_data[i]),
      .empty       (l_empty[i]),
      .full        (l_full[i]),
      .almost_full (l_af[i]),
      .overflow    (l_ovf[i])
    );
  end

  // Round-robin: with both lanes ready, serve the lane not served last.
  assign pop_ok = pop & ~(&l_empty);
  always_comb begin
    sel = ~last_served;
    if (l_empty[LANE0])      sel = LANE1;
    else if (l_empty[LANE1]) sel = LANE0;
  end
  assign lane_pop = pop_ok ? (sel ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      lane_out    <= LANE0;
      last_served <= LANE1;
    end else begin
      valid_out <= pop_ok;
      if (pop_ok) begin
        data_out    <= rd_data[sel];
        lane_out    <= sel;
        last_served <= sel;
      end
    end
  end

  assign empty        = &l_empty;
  assign full0        = l_full[LANE0];
  assign full1        = l_full[LANE1];
  assign almost_full0 = l_af[LANE0];
  assign almost_full1 = l_af[LANE1];
  assign overflow0    = l_ovf[LANE0];
  assign overflow1    = l_ovf[LANE1];

`ifdef LANE_MERGE_DROP_COUNT_EN
  logic [NUM_LANES-1:0][7:0] drop_cnt;
  logic [NUM_LANES-1:0]      drop;

  assign drop = push & l_full;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (drop[i] && drop_cnt[i] != 8'hFF) drop_cnt[i] <= drop_cnt[i] + 8'd1;
    end
  end

  assign drop_cnt0 = drop_cnt[LANE0];
  assign drop_cnt1 = drop_cnt[LANE1];
`endif
endmodule
